// File: rtl/gui_ctrl.sv
// gui_ctrl: button-driven colour / stroke-width selector for the GUI sprite.
// Button steps modify pending registers only. The outputs take the pending
// values at the frame origin (hcount_in==0, vcount_in==0), so the sprite
// never changes in the middle of a frame.
// Build option: define GUI_CTRL_REPEAT_EN to enable hold-to-auto-repeat.
// Without it, each press gives exactly one step.
module gui_ctrl #(
  parameter int HOLD_CYCLES   = 25000000,
  parameter int REPEAT_CYCLES = 6250000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        btn_color_up_in,
  input  logic        btn_color_down_in,
  input  logic        btn_width_up_in,
  input  logic        btn_width_down_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  output logic [3:0]  cursor_color_out,
  output logic [2:0]  stroke_width_out,
  output logic        changed_out
);

  // A single counter serves both the hold and the repeat intervals.
  localparam int MAX_CYCLES = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_HOLD   = 2'd1;
  localparam logic [1:0] S_REPEAT = 2'd2;
  localparam logic [1:0] S_LOCK   = 2'd3;

  // Button numbering: 0 colour up, 1 colour down, 2 width up, 3 width down.
  localparam logic [1:0] B_COLOR_UP   = 2'd0;
  localparam logic [1:0] B_COLOR_DOWN = 2'd1;
  localparam logic [1:0] B_WIDTH_UP   = 2'd2;

`ifdef GUI_CTRL_REPEAT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_owner;
  logic [3:0]       r_pend_color;
  logic [2:0]       r_pend_width;
  logic [3:0]       r_color;
  logic [2:0]       r_width;
  logic             r_changed;

  logic [1:0]       w_state_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic [1:0]       w_owner_next;
  logic             w_step;
  logic [1:0]       w_step_btn;
  logic [3:0]       w_btn;
  logic             w_any;
  logic             w_multi;
  logic [1:0]       w_press_idx;
  logic             w_owner_held;
  logic             w_other;
  logic             w_commit;

  assign w_btn        = {btn_width_down_in, btn_width_up_in, btn_color_down_in, btn_color_up_in};
  assign w_any        = |w_btn;
  // Clearing the lowest set bit leaves something only if two or more buttons are pressed.
  assign w_multi      = |(w_btn & (w_btn - 4'd1));
  assign w_owner_held = w_btn[r_owner];
  assign w_other      = |(w_btn & ~(4'b0001 << r_owner));
  assign w_commit     = (hcount_in == 11'd0) && (vcount_in == 10'd0);

  // Encode the index of the pressed button. It is only used when exactly one button is down.
  always_comb begin
    w_press_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (w_btn[i]) begin
        w_press_idx = 2'(i);
      end
    end
  end

  // Press/hold/repeat state machine: chooses the next state and when to step.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_owner_next = r_owner;
    w_step       = 1'b0;
    w_step_btn   = r_owner;
    case (r_state)
      S_IDLE: begin
        if (w_multi) begin
          w_state_next = S_LOCK;
        end else if (w_any) begin
          w_step       = 1'b1;
          w_step_btn   = w_press_idx;
          w_owner_next = w_press_idx;
          w_cnt_next   = '0;
          w_state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (!w_owner_held) begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
        end else if (w_other) begin
          w_state_next = S_LOCK;
          w_cnt_next   = '0;
        end else begin
`ifdef GUI_CTRL_REPEAT_EN
          if (r_cnt == HOLD_LAST) begin
            w_step       = 1'b1;
            w_cnt_next   = '0;
            w_state_next = S_REPEAT;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
`endif
        end
      end
      S_REPEAT: begin
        if (!w_owner_held) begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
        end else if (w_other) begin
          w_state_next = S_LOCK;
          w_cnt_next   = '0;
        end else begin
`ifdef GUI_CTRL_REPEAT_EN
          if (r_cnt == REPEAT_LAST) begin
            w_step     = 1'b1;
            w_cnt_next = '0;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
`else
          // This state is never entered when auto-repeat is disabled.
          w_state_next = S_IDLE;
`endif
        end
      end
      S_LOCK: begin
        if (!w_any) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Register the state machine, the hold counter and the owning button.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_owner <= 2'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_owner <= w_owner_next;
    end
  end

  // Apply steps to the pending values. Colour wraps and width saturates in 1..7.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_pend_color <= 4'h1;
      r_pend_width <= 3'd1;
    end else if (w_step) begin
      case (w_step_btn)
        B_COLOR_UP:   r_pend_color <= r_pend_color + 4'd1;
        B_COLOR_DOWN: r_pend_color <= r_pend_color - 4'd1;
        B_WIDTH_UP: begin
          if (r_pend_width != 3'd7) begin
            r_pend_width <= r_pend_width + 3'd1;
          end
        end
        default: begin
          if (r_pend_width != 3'd1) begin
            r_pend_width <= r_pend_width - 3'd1;
          end
        end
      endcase
    end
  end

  // Commit at the frame origin. A step taken in the same cycle is registered
  // only after this load, so it waits for the next frame origin.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_color   <= 4'h1;
      r_width   <= 3'd1;
      r_changed <= 1'b0;
    end else begin
      r_changed <= w_commit && ((r_pend_color != r_color) || (r_pend_width != r_width));
      if (w_commit) begin
        r_color <= r_pend_color;
        r_width <= r_pend_width;
      end
    end
  end

  assign cursor_color_out = r_color;
  assign stroke_width_out = r_width;
  assign changed_out      = r_changed;

endmodule

// File: tb/tb_gui_ctrl.sv
// tb_gui_ctrl: directed scenarios, then randomized button and commit
// activity. After every clock edge the outputs are compared with a cycle
// model built from the button rules: steps fall at press, then every
// REPEAT after HOLD cycles of holding.
module tb_gui_ctrl;
  localparam int HOLD = 10;
  localparam int REP  = 4;
`ifdef GUI_CTRL_REPEAT_EN
  localparam bit REP_ON = 1'b1;
`else
  localparam bit REP_ON = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        b_cu, b_cd, b_wu, b_wd;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic [3:0]  cursor_color_out;
  logic [2:0]  stroke_width_out;
  logic        changed_out;

  int checks = 0;
  int errors = 0;

  // Model state. m_owner: -1 means no button owns the press, 0..3 is the
  // owning button, and 4 means locked out.
  int m_pc, m_pw, m_cc, m_cw, m_chg, m_owner, m_age;

  always #5 clk_in = ~clk_in;

  gui_ctrl #(.HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)) dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .btn_color_up_in   (b_cu),
    .btn_color_down_in (b_cd),
    .btn_width_up_in   (b_wu),
    .btn_width_down_in (b_wd),
    .hcount_in         (hcount_in),
    .vcount_in         (vcount_in),
    .cursor_color_out  (cursor_color_out),
    .stroke_width_out  (stroke_width_out),
    .changed_out       (changed_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    assert (obs === 32'(exp)) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input int b);
    case (b)
      0: m_pc = (m_pc + 1) % 16;
      1: m_pc = (m_pc + 15) % 16;
      2: m_pw = (m_pw < 7) ? m_pw + 1 : 7;
      default: m_pw = (m_pw > 1) ? m_pw - 1 : 1;
    endcase
  endtask

  task automatic model_cycle();
    logic [3:0] b;
    int n;
    int idx;
    b = {b_wd, b_wu, b_cd, b_cu};
    n = $countones(b);
    idx = 0;
    for (int i = 0; i < 4; i++) if (b[i]) idx = i;
    if (rst_in) begin
      m_pc = 1; m_pw = 1; m_cc = 1; m_cw = 1; m_chg = 0; m_owner = -1; m_age = 0;
      return;
    end
    m_chg = 0;
    if (hcount_in == 11'd0 && vcount_in == 10'd0) begin
      m_chg = (m_cc != m_pc || m_cw != m_pw) ? 1 : 0;
      m_cc = m_pc;
      m_cw = m_pw;
    end
    if (m_owner == -1) begin
      if (n == 1) begin
        m_owner = idx; m_age = 0; model_step(idx);
      end else if (n > 1) begin
        m_owner = 4;
      end
    end else if (m_owner == 4) begin
      if (n == 0) m_owner = -1;
    end else begin
      if (!b[m_owner]) m_owner = -1;
      else if (n > 1) m_owner = 4;
      else begin
        m_age++;
        if (REP_ON && m_age >= HOLD && (m_age - HOLD) % REP == 0) model_step(m_owner);
      end
    end
  endtask

  // One clock: update the model at the edge, then compare the outputs 1 ns later.
  task automatic tick();
    @(posedge clk_in);
    model_cycle();
    #1;
    check("color", 32'(cursor_color_out), m_cc);
    check("width", 32'(stroke_width_out), m_cw);
    check("changed", 32'(changed_out), m_chg);
  endtask

  task automatic set_btn(input logic [3:0] b);
    {b_wd, b_wu, b_cd, b_cu} = b;
  endtask

  task automatic pulse(input logic [3:0] b);
    set_btn(b); tick();
    set_btn(4'b0000); tick();
  endtask

  task automatic commit();
    hcount_in = 11'd0; vcount_in = 10'd0; tick();
    hcount_in = 11'd100; vcount_in = 10'd3;
  endtask

  task automatic report(input string name);
    $display("step %s color=%0d width=%0d changed=%0d", name, cursor_color_out, stroke_width_out, changed_out);
  endtask

  int c_before;
  int w_before;

  initial begin
    m_pc = 1; m_pw = 1; m_cc = 1; m_cw = 1; m_chg = 0; m_owner = -1; m_age = 0;
    rst_in = 1'b1; set_btn(4'b0000); hcount_in = 11'd5; vcount_in = 10'd5;
    tick(); tick();
    rst_in = 1'b0;
    tick();
    check("reset_color", 32'(cursor_color_out), 1);
    check("reset_width", 32'(stroke_width_out), 1);
    check("reset_changed", 32'(changed_out), 0);
    report("reset");

    // Reset followed by a commit: nothing changes.
    commit();
    check("idle_commit_changed", 32'(changed_out), 0);
    tick();
    check("idle_commit_color", 32'(cursor_color_out), 1);
    report("idle_commit");

    // A three-cycle colour-up pulse steps once and appears only at the commit.
    set_btn(4'b0001); tick(); tick(); tick();
    set_btn(4'b0000); tick(); tick();
    check("pre_commit_color", 32'(cursor_color_out), 1);
    commit();
    check("pulse_color", 32'(cursor_color_out), 2);
    check("pulse_changed", 32'(changed_out), 1);
    tick();
    check("pulse_changed_drop", 32'(changed_out), 0);
    report("color_pulse");

    // Return to colour 1, then hold colour-down for 23 cycles (press plus 22 more).
    pulse(4'b0010);
    set_btn(4'b0010);
    for (int i = 0; i < 23; i++) tick();
    set_btn(4'b0000); tick();
    commit();
    check("hold_down_color", 32'(cursor_color_out), REP_ON ? 12 : 0);
    report("hold_color_down");

    // Width saturates at 7 on the way up and at 1 on the way down.
    for (int i = 0; i < 8; i++) pulse(4'b0100);
    commit();
    check("width_sat_hi", 32'(stroke_width_out), 7);
    report("width_up_x8");
    for (int i = 0; i < 8; i++) pulse(4'b1000);
    commit();
    check("width_sat_lo", 32'(stroke_width_out), 1);
    report("width_down_x8");

    // Two buttons pressed together lock out any step.
    c_before = m_cc;
    set_btn(4'b0101); tick(); tick(); tick();
    set_btn(4'b0000); tick();
    commit();
    check("lock_color", 32'(cursor_color_out), c_before);
    check("lock_width", 32'(stroke_width_out), 1);
    pulse(4'b0100);
    commit();
    check("unlock_width", 32'(stroke_width_out), 2);
    report("lock");

    // A press in the commit cycle is not visible until the next commit.
    c_before = m_cc;
    w_before = m_cw;
    hcount_in = 11'd0; vcount_in = 10'd0; set_btn(4'b0001); tick();
    hcount_in = 11'd50; vcount_in = 10'd7; set_btn(4'b0000); tick();
    check("commit_press_same", 32'(cursor_color_out), c_before);
    commit();
    check("commit_press_next", 32'(cursor_color_out), (c_before + 1) % 16);
    report("press_in_commit");

    // Reset while holding: everything returns to 1, and the held button counts as a new press.
    set_btn(4'b0100); tick(); tick();
    rst_in = 1'b1; tick();
    check("rst_hold_color", 32'(cursor_color_out), 1);
    check("rst_hold_width", 32'(stroke_width_out), 1);
    rst_in = 1'b0; tick(); tick();
    set_btn(4'b0000); tick();
    commit();
    check("rst_repress_width", 32'(stroke_width_out), 2);
    report("reset_while_hold");
    if (w_before < 0) $display("unreachable");

    // Randomized activity: button levels toggle slowly, with occasional commits and resets.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) b_cu = ~b_cu;
      if ($urandom_range(0, 7) == 0) b_cd = ~b_cd;
      if ($urandom_range(0, 11) == 0) b_wu = ~b_wu;
      if ($urandom_range(0, 11) == 0) b_wd = ~b_wd;
      if ($urandom_range(0, 15) == 0) begin
        hcount_in = 11'd0; vcount_in = 10'd0;
      end else begin
        hcount_in = 11'($urandom_range(0, 1279));
        vcount_in = 10'($urandom_range(1, 719));
      end
      rst_in = ($urandom_range(0, 599) == 0);
      tick();
    end
    rst_in = 1'b0;
    report("random_done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/gui_ctrl.md
GUI_CTRL -- requirements
Module: gui_ctrl

Interface
REQ-001 Parameter HOLD_CYCLES, default 25000000: cycles a button is held before auto-repeat starts.
REQ-002 Parameter REPEAT_CYCLES, default 6250000: cycles between auto-repeat steps.
REQ-003 clk_in  input  1  system/pixel clock; the block uses this single clock.
REQ-004 rst_in  input  1  reset, synchronous, active-high.
REQ-005 btn_color_up_in, btn_color_down_in, btn_width_up_in, btn_width_down_in  input  1 each  debounced active-high button levels.
REQ-006 hcount_in  input  11  current pixel column.
REQ-007 vcount_in  input  10  current pixel row.
REQ-008 cursor_color_out  output  4  committed palette index for the GUI sprite.
REQ-009 stroke_width_out  output  3  committed stroke width for the GUI sprite.
REQ-010 changed_out  output  1  one-cycle pulse when a commit changes either output.

Function
REQ-011 The block SHALL keep pending registers pend_color[3:0] and pend_width[2:0]; button steps modify only the pending registers.
REQ-012 Commit point: cycle where hcount_in==0 and vcount_in==0; outputs SHALL load the registered pending values and change at no other time.
REQ-013 A step applied in the commit cycle SHALL NOT be visible until the following commit.
REQ-014 changed_out SHALL be 1 for exactly the cycle after a commit in which either output changed value; 0 otherwise.
REQ-015 Color step: up = +1 mod 16 (15->0), down = -1 mod 16 (0->15).
REQ-016 Width step: up = +1 saturating at 7, down = -1 saturating at 1; width SHALL never be 0.
REQ-017 FSM states IDLE, HOLD, REPEAT, LOCK; one hold counter, width sufficient for max(HOLD_CYCLES, REPEAT_CYCLES).
REQ-018 IDLE: exactly one button asserted -> apply one step for that button, clear counter, go HOLD; two or more asserted -> LOCK, no step; none -> stay.
REQ-019 HOLD: held button released -> IDLE; any other button asserted -> LOCK; counter reaches HOLD_CYCLES-1 -> apply one step, clear counter, go REPEAT; else increment counter.
REQ-020 REPEAT: release -> IDLE; other button asserted -> LOCK; counter reaches REPEAT_CYCLES-1 -> apply one step, clear counter; else increment.
REQ-021 LOCK: no steps; all buttons released -> IDLE.
REQ-022 The block SHALL record which button owns HOLD/REPEAT and step only for that button.
REQ-023 Step latency: press seen in cycle N (IDLE) -> pending updated at end of cycle N.

Reset
REQ-024 On rst_in the block SHALL set state IDLE, counter 0, pend_color and cursor_color_out to 4'h1 (white), pend_width and stroke_width_out to 3'd1, changed_out 0, in the next cycle.
REQ-025 Reset mid-hold or mid-frame SHALL discard all pending steps; a still-held button after reset SHALL be treated as a new press (REQ-018).

Configuration
REQ-026 Macro GUI_CTRL_REPEAT_EN: defined -> HOLD->REPEAT auto-repeat per REQ-019/020.
REQ-027 GUI_CTRL_REPEAT_EN undefined -> HOLD SHALL never step or enter REPEAT; exactly one step per press, release returns IDLE.

Verification (HOLD_CYCLES=10, REPEAT_CYCLES=4)
REQ-028 Reset, then one commit -> color 1, width 1, changed_out stays 0.
REQ-029 Pulse color_up 3 cycles, then commit -> color 2, changed_out high one cycle; no output change before commit.
REQ-030 Hold color_down 22 cycles from color 1, macro on -> steps at press, +10, +14, +18, +22 cycles: pending 0,15,14,13,12; macro off -> pending 0 only.
REQ-031 Width_up pressed/released 8 times from 1 -> pending 7; width_down 8 times -> 1; never 0.
REQ-032 Color_up and width_up asserted same cycle -> LOCK, no change; release both, press width_up -> width 2.
REQ-033 Press color_up in commit cycle -> outputs unchanged at that commit, updated at next commit; rst_in while holding -> color 1, width 1 next cycle.
